// File: rtl/burst_arbiter_pkg.sv
// Shared types and constants for the burst arbiter and the units that talk to it.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package burst_arbiter_pkg;

    localparam int DEF_NUM_REQUESTERS = 4;
    localparam int DEF_MAX_BURST      = 8;
    localparam int DEF_LEN_WIDTH      = $clog2(DEF_MAX_BURST);

    // Burst length minus one, as presented by a requester at grant time.
    typedef logic [DEF_LEN_WIDTH-1:0] burst_len_t;

    // FSM encoding, kept as plain constants so older netlists can match it.
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;

endpackage

// File: rtl/burst_arbiter_if.sv
// Request/grant bundle between requesting units, the resource and the burst arbiter.
// Latency: n/a (wires only).
// Backpressure: ready from the resource stalls the current beat.
interface burst_arbiter_if #(
    parameter int NUM_REQUESTERS = 4,
    parameter int MAX_BURST      = 8
);
    import burst_arbiter_pkg::*;

    localparam int IDX_WIDTH = $clog2(NUM_REQUESTERS);
    localparam int LEN_WIDTH = $clog2(MAX_BURST);

    logic [NUM_REQUESTERS-1:0]                request;
    logic [NUM_REQUESTERS-1:0][LEN_WIDTH-1:0] burst_len;
    logic                                     ready;
    logic                                     grant_valid;
    logic [NUM_REQUESTERS-1:0]                grant_oh;
    logic [IDX_WIDTH-1:0]                     grant_idx;
    logic [LEN_WIDTH-1:0]                     beat_idx;
    logic                                     beat_accept;
    logic                                     last_beat;
    logic                                     abort;

    // Requesters and resource drive the request side and observe the grant.
    modport master (
        output request, burst_len, ready,
        input  grant_valid, grant_oh, grant_idx, beat_idx, beat_accept, last_beat, abort
    );

    // The arbiter consumes requests and produces the grant view.
    modport slave (
        input  request, burst_len, ready,
        output grant_valid, grant_oh, grant_idx, beat_idx, beat_accept, last_beat, abort
    );

endinterface

// File: rtl/burst_arbiter_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searched from a rotating priority pointer.
// Latency: grant is combinational from req_i; the pointer moves on the clock after update_lru_i.
// Backpressure: none; the caller decides when a grant is consumed via update_lru_i.
module rr_arbiter
    import burst_arbiter_pkg::*;
#(
    parameter int NUM_REQUESTERS = DEF_NUM_REQUESTERS
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQUESTERS-1:0] req_i,
    input  logic                      update_lru_i,
    output logic [NUM_REQUESTERS-1:0] grant_oh_o
);

    localparam int IDX_WIDTH = $clog2(NUM_REQUESTERS);

    logic [IDX_WIDTH-1:0] ptr_q, ptr_d;
    logic [IDX_WIDTH-1:0] win_idx;
    logic [IDX_WIDTH-1:0] cand;
    logic                 found;

    // Search requests starting at the pointer; first hit wins.
    always_comb begin
        grant_oh_o = '0;
        win_idx    = '0;
        cand       = '0;
        found      = 1'b0;
        for (int i = 0; i < NUM_REQUESTERS; i++) begin
            cand = IDX_WIDTH'((int'(ptr_q) + i) % NUM_REQUESTERS);
            if (!found && req_i[cand]) begin
                grant_oh_o[cand] = 1'b1;
                win_idx          = cand;
                found            = 1'b1;
            end
        end
    end

    // The winner becomes lowest priority once its grant is consumed.
    always_comb begin
        ptr_d = ptr_q;
        if (update_lru_i && found) begin
            ptr_d = (win_idx == IDX_WIDTH'(NUM_REQUESTERS - 1)) ? '0 : win_idx + 1'b1;
        end
    end

    // Priority pointer register; reset favours requester 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/burst_arbiter.sv
// Locks a round-robin winner onto a multi-beat resource port for its whole burst.
// Latency: request to grant_valid is 1 cycle; one idle cycle separates consecutive bursts.
// Backpressure: ready low holds the current beat; owner dropping request aborts the burst.
module burst_arbiter
    import burst_arbiter_pkg::*;
#(
    parameter int NUM_REQUESTERS = DEF_NUM_REQUESTERS,
    parameter int MAX_BURST      = DEF_MAX_BURST
) (
    input  logic            clk,
    input  logic            reset,
    burst_arbiter_if.slave  bus
);

    localparam int IDX_WIDTH = $clog2(NUM_REQUESTERS);
    localparam int LEN_WIDTH = $clog2(MAX_BURST);

    logic [0:0]                state_q, state_d;
    logic [NUM_REQUESTERS-1:0] grant_oh_q, grant_oh_d;
    logic [IDX_WIDTH-1:0]      grant_idx_q, grant_idx_d;
    logic [LEN_WIDTH-1:0]      remaining_q, remaining_d;
    logic [LEN_WIDTH-1:0]      beat_idx_q, beat_idx_d;

    logic [NUM_REQUESTERS-1:0] arb_grant;
    logic [IDX_WIDTH-1:0]      arb_idx;
    logic                      in_burst;
    logic                      owner_req;
    logic                      update_lru;
    logic                      beat_accept;
    logic                      last_beat;
    logic                      abort;

    // Handshake outputs depend only on registered state and the live request/ready,
    // so no combinational path runs through the arbiter search.
    assign in_burst    = (state_q == ST_BURST);
    assign owner_req   = |(bus.request & grant_oh_q);
    assign abort       = in_burst & ~owner_req;
    assign beat_accept = in_burst & owner_req & bus.ready;
    assign last_beat   = beat_accept & (remaining_q == '0);

    // Priority only rotates when a burst is granted, so it stays frozen mid-burst.
    assign update_lru  = (state_q == ST_IDLE) && (bus.request != '0);

    rr_arbiter #(
        .NUM_REQUESTERS (NUM_REQUESTERS)
    ) u_rr_arbiter (
        .clk          (clk),
        .reset        (reset),
        .req_i        (bus.request),
        .update_lru_i (update_lru),
        .grant_oh_o   (arb_grant)
    );

    // One-hot winner to binary index.
    always_comb begin
        arb_idx = '0;
        for (int i = 0; i < NUM_REQUESTERS; i++) begin
            if (arb_grant[i]) begin
                arb_idx = arb_idx | IDX_WIDTH'(i);
            end
        end
    end

    // Burst FSM: grant from IDLE, count beats in BURST, release on last beat or abort.
    always_comb begin
        state_d     = state_q;
        grant_oh_d  = grant_oh_q;
        grant_idx_d = grant_idx_q;
        remaining_d = remaining_q;
        beat_idx_d  = beat_idx_q;
        case (state_q)
            ST_IDLE: begin
                if (|bus.request) begin
                    state_d     = ST_BURST;
                    grant_oh_d  = arb_grant;
                    grant_idx_d = arb_idx;
                    remaining_d = bus.burst_len[arb_idx];
                    beat_idx_d  = '0;
                end
            end
            ST_BURST: begin
                if (abort || last_beat) begin
                    state_d     = ST_IDLE;
                    grant_oh_d  = '0;
                    grant_idx_d = '0;
                    remaining_d = '0;
                    beat_idx_d  = '0;
                end else if (beat_accept) begin
                    remaining_d = remaining_q - 1'b1;
                    beat_idx_d  = beat_idx_q + 1'b1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                grant_oh_d  = '0;
                grant_idx_d = '0;
                remaining_d = '0;
                beat_idx_d  = '0;
            end
        endcase
    end

    // State registers; reset drops any burst in flight without an abort pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            grant_oh_q  <= '0;
            grant_idx_q <= '0;
            remaining_q <= '0;
            beat_idx_q  <= '0;
        end else begin
            state_q     <= state_d;
            grant_oh_q  <= grant_oh_d;
            grant_idx_q <= grant_idx_d;
            remaining_q <= remaining_d;
            beat_idx_q  <= beat_idx_d;
        end
    end

    assign bus.grant_valid = in_burst;
    assign bus.grant_oh    = grant_oh_q;
    assign bus.grant_idx   = grant_idx_q;
    assign bus.beat_idx    = beat_idx_q;
    assign bus.beat_accept = beat_accept;
    assign bus.last_beat   = last_beat;
    assign bus.abort       = abort;

`ifndef SYNTHESIS
    a_onehot_owner: assert property (@(posedge clk) disable iff (reset) $onehot0(grant_oh_q));
    a_valid_owner:  assert property (@(posedge clk) disable iff (reset) in_burst == (grant_oh_q != '0));
    a_last_accept:  assert property (@(posedge clk) disable iff (reset) last_beat |-> beat_accept);
    a_abort_accept: assert property (@(posedge clk) disable iff (reset) !(abort && beat_accept));
`endif

endmodule

// File: tb/tb_burst_arbiter.sv
// Directed bench: stimulus pushes expected beats, a negedge monitor pops and compares.
module tb_burst_arbiter;
    import burst_arbiter_pkg::*;

    localparam int NR = 4;
    localparam int MB = 8;

    typedef struct packed {
        logic [1:0] idx;
        logic [2:0] beat;
        logic       acc;
        logic       last;
        logic       ab;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    burst_arbiter_if #(.NUM_REQUESTERS(NR), .MAX_BURST(MB)) bus ();

    burst_arbiter #(.NUM_REQUESTERS(NR), .MAX_BURST(MB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;

    logic bp_rdy  [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    int   bp_beat [5] = '{0, 0, 1, 1, 1};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_grant_valid"}, 32'(bus.grant_valid), 32'd0);
        check({pfx, "_grant_oh"},    32'(bus.grant_oh),    32'd0);
        check({pfx, "_grant_idx"},   32'(bus.grant_idx),   32'd0);
        check({pfx, "_beat_idx"},    32'(bus.beat_idx),    32'd0);
        check({pfx, "_beat_accept"}, 32'(bus.beat_accept), 32'd0);
        check({pfx, "_last_beat"},   32'(bus.last_beat),   32'd0);
        check({pfx, "_abort"},       32'(bus.abort),       32'd0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [NR-1:0] req, input logic rdy);
        bus.request = req;
        bus.ready   = rdy;
    endtask

    task automatic expect_beat(input int idx, input int beat, input logic acc,
                               input logic last, input logic ab);
        exp_t e;
        e.idx  = 2'(idx);
        e.beat = 3'(beat);
        e.acc  = acc;
        e.last = last;
        e.ab   = ab;
        sb_q.push_back(e);
    endtask

    task automatic do_reset(input string pfx);
        reset = 1'b1;
        drive('0, 1'b0);
        bus.burst_len = '0;
        #1;
        check_all_zero(pfx);
        step();
        step();
        reset = 1'b0;
    endtask

    // Monitor: any visible grant activity must match the next expected beat.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (bus.grant_valid || bus.abort || bus.beat_accept || bus.last_beat || (bus.grant_oh != '0)) begin
                if (sb_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_output: got grant_idx=%0d beat_idx=%0d abort=%0d, required no activity",
                             bus.grant_idx, bus.beat_idx, bus.abort);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("grant_valid", 32'(bus.grant_valid), 32'd1);
                    check("grant_oh",    32'(bus.grant_oh),    32'd1 << mon_e.idx);
                    check("grant_idx",   32'(bus.grant_idx),   32'(mon_e.idx));
                    check("beat_idx",    32'(bus.beat_idx),    32'(mon_e.beat));
                    check("beat_accept", 32'(bus.beat_accept), 32'(mon_e.acc));
                    check("last_beat",   32'(bus.last_beat),   32'(mon_e.last));
                    check("abort",       32'(bus.abort),       32'(mon_e.ab));
                end
            end else begin
                check("idle_grant_idx", 32'(bus.grant_idx), 32'd0);
                check("idle_beat_idx",  32'(bus.beat_idx),  32'd0);
            end
        end
    end

    initial begin
        reset = 1'b1;
        bus.request   = '0;
        bus.burst_len = '0;
        bus.ready     = 1'b0;
        #3;
        check_all_zero("por");
        step();
        step();
        reset = 1'b0;

        // Single burst: unit 1, four beats.
        drive(4'b0010, 1'b1);
        bus.burst_len[1] = 3'd3;
        step();
        for (int b = 0; b < 4; b++) begin
            expect_beat(1, b, 1'b1, (b == 3), 1'b0);
            step();
        end
        drive('0, 1'b0);
        step();

        // Round-robin with single-beat bursts and an idle cycle between grants.
        do_reset("rst_rr");
        bus.burst_len = '0;
        drive(4'b1111, 1'b1);
        for (int k = 0; k < 5; k++) begin
            step();
            expect_beat(k % 4, 0, 1'b1, 1'b1, 1'b0);
            step();
        end
        drive('0, 1'b0);
        step();

        // Backpressure: unit 0, two beats, ready 0,1,0,0,1.
        bus.burst_len[0] = 3'd1;
        drive(4'b0001, 1'b0);
        step();
        for (int i = 0; i < 5; i++) begin
            bus.ready = bp_rdy[i];
            expect_beat(0, bp_beat[i], bp_rdy[i], (i == 4), 1'b0);
            step();
        end
        drive('0, 1'b0);
        step();

        // Abort: unit 2 drops request after two beats; unit 3 then wins over 0 and 1.
        bus.burst_len[2] = 3'd7;
        drive(4'b0100, 1'b1);
        step();
        expect_beat(2, 0, 1'b1, 1'b0, 1'b0);
        step();
        expect_beat(2, 1, 1'b1, 1'b0, 1'b0);
        step();
        drive(4'b1000, 1'b1);
        expect_beat(2, 2, 1'b0, 1'b0, 1'b1);
        step();
        bus.burst_len[3] = 3'd0;
        drive(4'b1011, 1'b1);
        step();
        expect_beat(3, 0, 1'b1, 1'b1, 1'b0);
        step();
        drive('0, 1'b0);
        step();

        // Maximum length: eight beats, beat index must not wrap.
        bus.burst_len[1] = 3'd7;
        drive(4'b0010, 1'b1);
        step();
        for (int b = 0; b < 8; b++) begin
            expect_beat(1, b, 1'b1, (b == 7), 1'b0);
            step();
        end
        drive('0, 1'b0);
        step();

        // Reset at beat 2 clears outputs at once and restores priority to unit 0.
        bus.burst_len[2] = 3'd7;
        drive(4'b0100, 1'b1);
        step();
        expect_beat(2, 0, 1'b1, 1'b0, 1'b0);
        step();
        expect_beat(2, 1, 1'b1, 1'b0, 1'b0);
        step();
        reset = 1'b1;
        #1;
        check_all_zero("mid_reset");
        step();
        step();
        reset = 1'b0;
        bus.burst_len = '0;
        drive(4'b1111, 1'b1);
        step();
        expect_beat(0, 0, 1'b1, 1'b1, 1'b0);
        step();
        drive('0, 1'b0);
        step();
        step();
        step();

        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/burst_arbiter.md
Name: burst_arbiter

Overview:
- Shares one multi-beat resource port (e.g. L2 request bus, memory write port) among NUM_REQUESTERS units.
- Picks a winner round-robin using the existing rr_arbiter, then locks the grant for the requester's whole burst. Releases the grant on the last accepted beat or on abort.
- Sits between the requesting units and the resource; the resource side sees only grant_valid/ready and beat counters.

Parameters:
- NUM_REQUESTERS, 4, number of requesting units (>= 2).
- MAX_BURST, 8, maximum beats per burst, power of two (>= 2).
- Derived localparams: IDX_WIDTH = $clog2(NUM_REQUESTERS); LEN_WIDTH = $clog2(MAX_BURST).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- request  in  NUM_REQUESTERS  per-unit burst request; must be held until that unit's last beat.
- burst_len  in  NUM_REQUESTERS x LEN_WIDTH  per-unit burst length minus 1; sampled only at grant.
- ready  in  1  resource accepts the current beat this cycle.
- grant_valid  out  1  a locked burst is in progress.
- grant_oh  out  NUM_REQUESTERS  registered one-hot owner; zero when not grant_valid.
- grant_idx  out  IDX_WIDTH  binary index of owner; 0 when idle.
- beat_idx  out  LEN_WIDTH  index of current beat within the burst (0-based).
- beat_accept  out  1  grant_valid & ready: beat transferred this cycle.
- last_beat  out  1  beat_accept on the final beat.
- abort  out  1  one-cycle pulse: owner dropped request before its last beat.

Behaviour:
- Reset values: state IDLE; grant_valid 0, grant_oh 0, grant_idx 0, beat_idx 0, beat_accept 0, last_beat 0, abort 0. Internal rr_arbiter priority returns to requester 0.
- FSM states: IDLE and BURST.
- IDLE:
  - rr_arbiter is fed request with update_lru = (request != 0).
  - If any request is set, register the arbiter's grant_oh into grant_oh and its encoded index into grant_idx.
  - Latch remaining = burst_len[winner] and set beat_idx = 0, then go to BURST.
  - Arbitration latency is 1 cycle: request in cycle N gives grant_valid in cycle N+1.
- BURST:
  - rr_arbiter's update_lru is held 0, so priority is frozen during the burst.
  - On ready with remaining != 0: decrement remaining, increment beat_idx, stay in BURST.
  - On ready with remaining == 0: assert last_beat combinationally in that cycle. Next cycle is IDLE with grant_oh cleared.
  - There is one mandatory idle cycle between bursts; no back-to-back grant.
  - If the owner's request bit is 0 while in BURST: assert abort combinationally that cycle and suppress beat_accept/last_beat even if ready is 1. Next state is IDLE, counters cleared.
  - Request bits of non-owners are ignored during BURST.
- Outputs derived from registered state: grant_valid, grant_oh, grant_idx, beat_idx.
- Combinational outputs: beat_accept, last_beat, abort. All combinational paths from ready/request are gated by state only, never from the arbiter.
- Widths:
  - remaining and beat_idx are LEN_WIDTH bits. A burst_len of all ones gives MAX_BURST beats, and beat_idx never wraps within a burst.
  - burst_len of 0 gives a single beat; last_beat is set on the first accept.
- Fairness: because update_lru is pulsed only at grant, the priority rotates once per burst. With all units requesting continuously, grants go 0,1,2,3,0,...
- Reset mid-burst: immediate return to IDLE, all outputs 0, priority back to unit 0. No abort pulse.
- Assertions (simulation only):
  - $onehot0(grant_oh).
  - grant_valid == (grant_oh != 0).
  - last_beat implies beat_accept.
  - abort and beat_accept are never both 1.

Decomposition:
- Shared package: none required. If the interconnect package already exists, add the burst-length typedef (logic[LEN_WIDTH-1:0]) there for reuse by requesters.
- Sub-module: one instance of rr_arbiter (NUM_REQUESTERS), driven as described.
- One-hot-to-index conversion uses the team's existing oh_to_idx helper if present; otherwise an inline loop.

Test Plan:
- Single burst: reset; request=4'b0010, burst_len[1]=3, ready=1 -> grant_valid cycle 1, grant_oh=0010, grant_idx=1, beat_idx 0..3, last_beat at beat 3, IDLE next cycle.
- Round-robin: request=4'b1111, all burst_len=0, ready=1 -> grant_idx sequence 0,1,2,3,0, with one idle cycle between grants.
- Backpressure: grant to unit 0 with burst_len=1; ready toggles 0,1,0,0,1 -> beat_accept only on ready cycles, beat_idx 0,1, last_beat on 5th cycle, grant held throughout.
- Abort: unit 2 granted with burst_len=7; drop request[2] after 2 accepts while ready=1 -> abort=1 that cycle, beat_accept=0, IDLE next, next grant goes to unit 3 if requesting.
- Max length: burst_len=3'b111, MAX_BURST=8 -> exactly 8 beat_accepts, beat_idx 0..7, no wrap.
- Reset mid-burst: assert reset at beat 2 -> all outputs 0 asynchronously. After release, request=4'b1111 grants unit 0 first.
